// File: rtl/oflow_score_board_pkg.sv
// Shared types and constants for the optical-flow score board.
package oflow_score_board_pkg;

  localparam int unsigned SB_SCORE_LEN = 32;
  localparam int unsigned SB_ID_LEN    = 12;
  localparam int unsigned SB_NUM_IDS   = 64;
  localparam int unsigned SB_NUM_OBJS  = 64;
  localparam int unsigned SB_OBJ_LEN   = 6;

  localparam logic [SB_SCORE_LEN-1:0] SCORE_INVALID = '1;

  typedef enum logic [1:0] {IDLE, CLAIM, DONE} sb_state_t;

  typedef struct packed {
    logic                    valid;
    logic [SB_SCORE_LEN-1:0] score;
    logic [SB_OBJ_LEN-1:0]   owner;
    logic                    level;
  } sb_entry_t;

  typedef struct packed {
    logic [SB_SCORE_LEN-1:0] second_score;
    logic [SB_ID_LEN-1:0]    second_id;
    logic                    second_ok;
    logic [SB_ID_LEN-1:0]    asg_id;
    logic                    asg_valid;
  } obj_entry_t;

  // A candidate can be claimed only with a real score and an ID on the board.
  function automatic logic usable(input logic [SB_SCORE_LEN-1:0] score,
                                  input logic [SB_ID_LEN-1:0]    id);
    return (score != SCORE_INVALID) && (id < SB_ID_LEN'(SB_NUM_IDS));
  endfunction

endpackage

// File: rtl/oflow_sb_regfile.sv
// Per-ID claim board: one combinational read port, one write port, clear-all.
module oflow_sb_regfile
  import oflow_score_board_pkg::*;
#(
  parameter int unsigned NUM_IDS = SB_NUM_IDS,
  parameter int unsigned IDX_W   = $clog2(SB_NUM_IDS)
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_addr,
  output sb_entry_t        rd_data_c,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  sb_entry_t        wr_data
);

  sb_entry_t board [NUM_IDS];

  assign rd_data_c = board[rd_addr];

  // Clear only needs the valid bits; stale payloads are never trusted.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < int'(NUM_IDS); i++) board[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(NUM_IDS); i++) board[i].valid <= 1'b0;
    end else if (we) begin
      board[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/oflow_score_board.sv
// Greedy per-frame ID assignment with a single second-choice fallback per object.
module oflow_score_board
  import oflow_score_board_pkg::*;
#(
  parameter int unsigned SCORE_LEN = SB_SCORE_LEN,
  parameter int unsigned ID_LEN    = SB_ID_LEN,
  parameter int unsigned NUM_IDS   = SB_NUM_IDS,
  parameter int unsigned NUM_OBJS  = SB_NUM_OBJS,
  parameter int unsigned OBJ_LEN   = SB_OBJ_LEN
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_frame,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [OBJ_LEN-1:0]   obj_idx,
  input  logic [SCORE_LEN-1:0] min_score_0,
  input  logic [ID_LEN-1:0]    min_id_0,
  input  logic [SCORE_LEN-1:0] min_score_1,
  input  logic [ID_LEN-1:0]    min_id_1,
  output logic                 done_obj,
  output logic                 busy,
  input  logic [OBJ_LEN-1:0]   rd_obj_idx,
  output logic [ID_LEN-1:0]    rd_id,
  output logic                 rd_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_IDS);

  sb_state_t            state;
  logic [OBJ_LEN-1:0]   cur;
  logic [ID_LEN-1:0]    cand_id;
  logic [SCORE_LEN-1:0] cand_score;
  logic                 level;
  obj_entry_t           obj_tab [NUM_OBJS];

  sb_entry_t  e_c;
  sb_entry_t  wr_entry_c;
  obj_entry_t own_c;
  obj_entry_t cur_c;
  logic       ok0_c, ok1_c, win_c, we_c, retry_c;

  // Claim decision against the board entry the current candidate points at.
  always_comb begin
    ok0_c      = usable(min_score_0, min_id_0);
    ok1_c      = usable(min_score_1, min_id_1);
    own_c      = obj_tab[e_c.owner];
    cur_c      = obj_tab[cur];
    win_c      = !e_c.valid || (cand_score < e_c.score);
    we_c       = (state == CLAIM) && win_c && !start_frame;
    retry_c    = e_c.valid && !e_c.level && own_c.second_ok;
    wr_entry_c = '{valid: 1'b1, score: cand_score, owner: cur, level: level};
  end

  oflow_sb_regfile #(
    .NUM_IDS (NUM_IDS),
    .IDX_W   (IDX_W)
  ) u_board (
    .clk       (clk),
    .reset_N   (reset_N),
    .clr       (start_frame),
    .rd_addr   (cand_id[IDX_W-1:0]),
    .rd_data_c (e_c),
    .we        (we_c),
    .wr_addr   (cand_id[IDX_W-1:0]),
    .wr_data   (wr_entry_c)
  );

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state      <= IDLE;
      cur        <= '0;
      cand_id    <= '0;
      cand_score <= '0;
      level      <= 1'b0;
      wr_ready   <= 1'b1;
      done_obj   <= 1'b0;
      busy       <= 1'b0;
      rd_id      <= '0;
      rd_valid   <= 1'b0;
      for (int i = 0; i < int'(NUM_OBJS); i++) obj_tab[i] <= '0;
    end else begin
      rd_id    <= obj_tab[rd_obj_idx].asg_id;
      rd_valid <= obj_tab[rd_obj_idx].asg_valid;
      done_obj <= 1'b0;
      if (start_frame) begin
        for (int i = 0; i < int'(NUM_OBJS); i++) begin
          obj_tab[i].asg_valid <= 1'b0;
          obj_tab[i].second_ok <= 1'b0;
        end
        state    <= IDLE;
        wr_ready <= 1'b1;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (wr_valid) begin
              obj_tab[obj_idx] <= '{second_score: min_score_1, second_id: min_id_1,
                                    second_ok: ok1_c, asg_id: '0, asg_valid: 1'b0};
              cur <= obj_idx;
              if (ok0_c || ok1_c) begin
                cand_score <= ok0_c ? min_score_0 : min_score_1;
                cand_id    <= ok0_c ? min_id_0 : min_id_1;
                level      <= !ok0_c;
                state      <= CLAIM;
                busy       <= 1'b1;
                wr_ready   <= 1'b0;
              end else begin
                done_obj <= 1'b1;
              end
            end
          end
          CLAIM: begin
            if (win_c) begin
              if (e_c.valid) obj_tab[e_c.owner].asg_valid <= 1'b0;
              obj_tab[cur].asg_id    <= cand_id;
              obj_tab[cur].asg_valid <= 1'b1;
            end
            // Displaced first-choice owner retries once; a losing first choice falls back.
            if (win_c && retry_c) begin
              cur        <= e_c.owner;
              cand_score <= own_c.second_score;
              cand_id    <= own_c.second_id;
              level      <= 1'b1;
            end else if (!win_c && !level && cur_c.second_ok) begin
              cand_score <= cur_c.second_score;
              cand_id    <= cur_c.second_id;
              level      <= 1'b1;
            end else begin
              state    <= DONE;
              busy     <= 1'b0;
              done_obj <= 1'b1;
            end
          end
          DONE: begin
            state    <= IDLE;
            wr_ready <= 1'b1;
          end
          default: begin
            state    <= IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/oflow_score_board.md
# oflow_score_board

Per-frame assignment table that sits directly downstream of the min-score calculator. For each current-frame object it accepts the two best candidates, {min_score_0, min_id_0} and {min_score_1, min_id_1}, and claims the previous-frame ID with the lowest score. Conflicts are resolved greedily: an owner displaced from its first choice falls back once to its second choice. Final per-object assignments are readable by the core once the frame's objects have all been written.

## Interface
Parameters:
- SCORE_LEN, 32, score width (matches calc-min output)
- ID_LEN, 12, previous-frame ID width
- NUM_IDS, 64, board depth; legal IDs 0..NUM_IDS-1
- NUM_OBJS, 64, max current-frame objects per frame
- OBJ_LEN, 6, object index width (clog2 NUM_OBJS)

Ports:
- clk  in  1  clock
- reset_N  in  1  asynchronous, active-low reset
- start_frame  in  1  pulse; clears board and object tables
- wr_valid  in  1  candidate pair valid (driven from done_calc_min)
- wr_ready  out  1  high only in IDLE
- obj_idx  in  OBJ_LEN  current object index
- min_score_0 / min_id_0  in  SCORE_LEN / ID_LEN  best candidate
- min_score_1 / min_id_1  in  SCORE_LEN / ID_LEN  second candidate
- done_obj  out  1  one-cycle pulse when an object's claim chain ends
- busy  out  1  high in CLAIM
- rd_obj_idx  in  OBJ_LEN  readback index
- rd_id  out  ID_LEN  assigned ID, registered
- rd_valid  out  1  object holds an assignment, registered

## Operation
- Board entry per ID: {valid, score, owner (OBJ_LEN), level (0 = first choice, 1 = second)}.
- Object table per object: {second_score, second_id, second_ok, asg_id, asg_valid}.
- SCORE_INVALID = all ones; a candidate is unusable if its score equals SCORE_INVALID or its ID is >= NUM_IDS.
- IDLE: on wr_valid && wr_ready, latch obj_idx into cur and load the object table with second_ok = (candidate 1 usable) and asg_valid = 0. Set cand = candidate 0, level = 0.
  - If candidate 0 is unusable: use candidate 1 with level = 1.
  - If both candidates are unusable: pulse done_obj and stay in IDLE.
  - Otherwise, go to CLAIM.
- CLAIM, one claim per cycle, reading e = board[cand_id]:
  - win if !e.valid or cand_score < e.score (strict; a tie keeps the incumbent).
  - On win: write the entry {1, cand_score, cur, level} and set asg[cur] = {cand_id, 1}.
    - If e.valid: clear asg[e.owner].valid. If e.level == 0 and second_ok[e.owner]: set cur = e.owner, cand = its second choice, level = 1, and stay in CLAIM. Otherwise go to DONE.
    - If !e.valid: go to DONE.
  - On lose: if level == 0 and second_ok[cur], switch to the second choice with level = 1 and stay in CLAIM. Otherwise go to DONE (cur stays unassigned).
- DONE: pulse done_obj and return to IDLE.
- Termination: each object claims at most twice per frame, so a chain is at most 2*NUM_OBJS cycles.
- start_frame has priority in every state. It clears all valid bits (board and objects) on the next edge and forces IDLE; a wr_valid in the same cycle is dropped.
- Readback: rd_id and rd_valid register asg[rd_obj_idx] every cycle, independent of FSM state. Readback is meaningful only while the FSM is in IDLE.

## Timing
- Reset: state = IDLE; all valid bits 0; wr_ready = 1; done_obj = 0; busy = 0; rd_id = 0; rd_valid = 0.
- Uncontested claim: accept at edge N, CLAIM during cycle N+1, DONE during N+2 with done_obj = 1, wr_ready = 1 again in N+3.
- Each fallback or displacement retry adds one cycle.
- Readback latency: 1 cycle.
- Board and table writes land on the edge that ends the CLAIM cycle; a same-cycle read observes old data.
- wr_valid while wr_ready = 0 is ignored; upstream must hold the pair or wait.
- Reset asserted mid-chain aborts immediately; partial claims are lost.

## Structure
- Package oflow_score_board_pkg holds:
  - sb_entry_t struct, obj_entry_t struct
  - sb_state_t enum {IDLE, CLAIM, DONE}
  - SCORE_INVALID constant
- Sub-module oflow_sb_regfile holds the board: NUM_IDS x sb_entry_t, one combinational read port, one write port, and a synchronous clear-all input driven by start_frame. The object table stays in the top level.

## Test plan
- Reset, then obj 0 with {5, id 3}, {9, id 7} -> done_obj 2 cycles after accept; rd_obj_idx = 0 gives rd_id = 3, rd_valid = 1.
- Obj 0 {10, id 3} / {20, id 4}, then obj 1 {4, id 3} / {30, id 5} -> obj 1 takes ID 3; obj 0 falls back to ID 4; board[4].level = 1; the chain adds one cycle.
- Obj 0 {4, id 3}, then obj 1 {4, id 3} / {SCORE_INVALID, id 0} -> tie keeps obj 0; obj 1 has rd_valid = 0.
- Obj 0 takes ID 4 at level 1, then obj 2 {1, id 4} -> obj 0 is displaced and left unassigned (no third try).
- min_id_0 = 70 (>= NUM_IDS) with min_score_1 = 8, min_id_1 = 2 -> ID 2 is claimed at level 1.
- start_frame asserted during a CLAIM chain together with wr_valid -> FSM returns to IDLE; all rd_valid = 0; the new pair is not accepted.
